// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared defaults and types for the multi-port register file
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW       = $clog2(NREG_DEF);

  typedef logic [AW-1:0]       reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : per-register busy bits and the RAW/WAW decode stall
// Revision           : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR-1:0]    wb_clr,
  input  logic [NRD-1:0]    re,
  input  logic [NRD*AW-1:0] raddr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  output logic              stall_o,
  output logic [NREG-1:0]   busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] w_clr_vec;
  logic            w_raw;
  logic            w_waw;

  always_comb begin
    w_clr_vec = '0;
    for (int k = 0; k < NWR; k++) begin
      if (we[k] && wb_clr[k]) w_clr_vec[waddr[k*AW +: AW]] = 1'b1;
    end
  end

  // A result retiring this cycle is forwarded, so it no longer blocks decode.
  always_comb begin
    w_raw = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      if (re[j] && (raddr[j*AW +: AW] != '0) &&
          busy_q[raddr[j*AW +: AW]] && !w_clr_vec[raddr[j*AW +: AW]])
        w_raw = 1'b1;
    end
    w_waw   = iss_valid && (iss_rd != '0) && busy_q[iss_rd] && !w_clr_vec[iss_rd];
    stall_o = !rst && !flush && (w_raw || w_waw);
  end

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q & ~w_clr_vec;
    if (iss_valid && !stall_o) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : multi-port register file with write forwarding and scoreboard
// Revision   : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*$clog2(NREG)-1:0]  waddr,
  input  logic [NWR*XLEN-1:0]   wdata,
  input  logic [NWR-1:0]        wb_clr,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*$clog2(NREG)-1:0]  raddr,
  output logic [NRD*XLEN-1:0]   rdata,
  input  logic                  iss_valid,
  input  logic [$clog2(NREG)-1:0]      iss_rd,
  input  logic                  flush,
  output logic                  stall_o,
  output logic [NREG-1:0]       busy_o
);

  localparam int ADDR_W = $clog2(NREG);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  // Later ports overwrite earlier ones, giving the higher index priority.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NWR; k++) begin
      if (we[k]) mem_d[waddr[k*ADDR_W +: ADDR_W]] = wdata[k*XLEN +: XLEN];
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < NRD; j++) begin
      if (!rst && re[j] && (raddr[j*ADDR_W +: ADDR_W] != '0)) begin
        rdata[j*XLEN +: XLEN] = mem_q[raddr[j*ADDR_W +: ADDR_W]];
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W]))
            rdata[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR),
    .AW   (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wb_clr    (wb_clr),
    .re        (re),
    .raddr     (raddr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .stall_o   (stall_o),
    .busy_o    (busy_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp : directed vector bench for regfile_mp (2 read, 2 write ports)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;
  import regfile_pkg::*;

  typedef struct {
    string     name;
    logic [1:0] we;
    reg_addr_t wa0;
    reg_data_t wd0;
    reg_addr_t wa1;
    reg_data_t wd1;
    logic [1:0] clr;
    logic [1:0] re;
    reg_addr_t ra0;
    reg_addr_t ra1;
    logic      iv;
    reg_addr_t rd;
    logic      fl;
    reg_data_t e0;
    reg_data_t e1;
    logic      es;
    logic [31:0] eb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  wb_clr;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        iss_valid;
  reg_addr_t   iss_rd;
  logic        flush;
  logic        stall_o;
  logic [31:0] busy_o;

  int n_checks = 0;
  int n_err    = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wb_clr(wb_clr),
    .re(re), .raddr(raddr), .rdata(rdata), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush), .stall_o(stall_o), .busy_o(busy_o)
  );

  function automatic vec_t v(string name, logic [1:0] we_i, reg_addr_t wa0, reg_data_t wd0,
                             reg_addr_t wa1, reg_data_t wd1, logic [1:0] clr, logic [1:0] re_i,
                             reg_addr_t ra0, reg_addr_t ra1, logic iv, reg_addr_t rd, logic fl,
                             reg_data_t e0, reg_data_t e1, logic es, logic [31:0] eb);
    vec_t t;
    t.name = name; t.we = we_i; t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
    t.clr = clr; t.re = re_i; t.ra0 = ra0; t.ra1 = ra1; t.iv = iv; t.rd = rd; t.fl = fl;
    t.e0 = e0; t.e1 = e1; t.es = es; t.eb = eb;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    we = t.we; waddr = {t.wa1, t.wa0}; wdata = {t.wd1, t.wd0}; wb_clr = t.clr;
    re = t.re; raddr = {t.ra1, t.ra0}; iss_valid = t.iv; iss_rd = t.rd; flush = t.fl;
  endtask

  task automatic idle();
    drive(v("idle", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 2'b00, 5'd0, 5'd0,
            1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0));
  endtask

  initial begin
    // Cycle-by-cycle script: inputs held for one cycle, outputs checked mid-cycle.
    //              name       we     wa0   wd0           wa1   wd1        clr    re     ra0   ra1   iv rd    fl  e0            e1            es  busy
    tbl.push_back(v("wr5_fwd", 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,     2'b00, 2'b01, 5'd5, 5'd9, 0, 5'd0, 0, 32'hDEADBEEF, 32'h0,        0, 32'h0));
    tbl.push_back(v("rd5_arr", 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b11, 5'd5, 5'd6, 0, 5'd0, 0, 32'hDEADBEEF, 32'h0,        0, 32'h0));
    tbl.push_back(v("wr7_conf",2'b11, 5'd7, 32'h1111,     5'd7, 32'h2222,  2'b00, 2'b11, 5'd7, 5'd5, 0, 5'd0, 0, 32'h2222,     32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(v("rd7_arr", 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b11, 5'd7, 5'd7, 0, 5'd0, 0, 32'h2222,     32'h2222,     0, 32'h0));
    tbl.push_back(v("iss_rd3", 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b01, 5'd3, 5'd0, 1, 5'd3, 0, 32'h0,        32'h0,        0, 32'h0));
    tbl.push_back(v("lu_t1",   2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b01, 5'd3, 5'd0, 0, 5'd0, 0, 32'h0,        32'h0,        1, 32'h8));
    tbl.push_back(v("lu_t2",   2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b01, 5'd3, 5'd0, 1, 5'd8, 0, 32'h0,        32'h0,        1, 32'h8));
    tbl.push_back(v("lu_t3",   2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b01, 5'd3, 5'd0, 0, 5'd0, 0, 32'h0,        32'h0,        1, 32'h8));
    tbl.push_back(v("lu_t4",   2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b01, 5'd3, 5'd0, 0, 5'd0, 0, 32'h0,        32'h0,        1, 32'h8));
    tbl.push_back(v("lu_t5",   2'b10, 5'd0, 32'h0,        5'd3, 32'h55,    2'b10, 2'b01, 5'd3, 5'd0, 0, 5'd0, 0, 32'h55,       32'h0,        0, 32'h8));
    tbl.push_back(v("lu_t6",   2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b01, 5'd3, 5'd0, 0, 5'd0, 0, 32'h55,       32'h0,        0, 32'h0));
    tbl.push_back(v("iss_rd4", 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b00, 5'd0, 5'd0, 1, 5'd4, 0, 32'h0,        32'h0,        0, 32'h0));
    tbl.push_back(v("waw4",    2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b00, 5'd0, 5'd0, 1, 5'd4, 0, 32'h0,        32'h0,        1, 32'h10));
    tbl.push_back(v("setclr4", 2'b01, 5'd4, 32'h44,       5'd0, 32'h0,     2'b01, 2'b00, 5'd0, 5'd0, 1, 5'd4, 0, 32'h0,        32'h0,        0, 32'h10));
    tbl.push_back(v("still4",  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b00, 5'd0, 5'd0, 0, 5'd0, 0, 32'h0,        32'h0,        0, 32'h10));
    tbl.push_back(v("noclr4",  2'b01, 5'd4, 32'h99,       5'd0, 32'h0,     2'b00, 2'b01, 5'd4, 5'd0, 0, 5'd0, 0, 32'h99,       32'h0,        1, 32'h10));
    tbl.push_back(v("clr4",    2'b10, 5'd0, 32'h0,        5'd4, 32'hAA,    2'b10, 2'b01, 5'd4, 5'd0, 0, 5'd0, 0, 32'hAA,       32'h0,        0, 32'h10));
    tbl.push_back(v("free4",   2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b01, 5'd4, 5'd0, 0, 5'd0, 0, 32'hAA,       32'h0,        0, 32'h0));
    tbl.push_back(v("iss_rd1", 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b00, 5'd0, 5'd0, 1, 5'd1, 0, 32'h0,        32'h0,        0, 32'h0));
    tbl.push_back(v("iss_rd2", 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b00, 5'd0, 5'd0, 1, 5'd2, 0, 32'h0,        32'h0,        0, 32'h2));
    tbl.push_back(v("iss_rd9", 2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b00, 5'd0, 5'd0, 1, 5'd9, 0, 32'h0,        32'h0,        0, 32'h6));
    tbl.push_back(v("flush",   2'b01, 5'd12,32'hC0FFEE,   5'd0, 32'h0,     2'b00, 2'b01, 5'd1, 5'd0, 1, 5'd10,1, 32'h0,        32'h0,        0, 32'h206));
    tbl.push_back(v("postfl",  2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b11, 5'd12,5'd1, 0, 5'd0, 0, 32'hC0FFEE,   32'h0,        0, 32'h0));
    tbl.push_back(v("x0_wr",   2'b11, 5'd0, 32'hFFFF,     5'd0, 32'hFFFF,  2'b11, 2'b11, 5'd0, 5'd0, 1, 5'd0, 0, 32'h0,        32'h0,        0, 32'h0));
    tbl.push_back(v("x0_rd",   2'b00, 5'd0, 32'h0,        5'd0, 32'h0,     2'b00, 2'b01, 5'd0, 5'd0, 0, 5'd0, 0, 32'h0,        32'h0,        0, 32'h0));

    // Reset with a write, a read and an issue presented; none may take effect.
    idle();
    rst = 1'b1;
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h12345678}; wb_clr = 2'b01;
    re = 2'b11; raddr = {5'd5, 5'd5}; iss_valid = 1'b1; iss_rd = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_stall", {63'h0, stall_o}, 64'h0);
    chk("rst_busy",  {32'h0, busy_o}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    re = 2'b01; raddr = {5'd0, 5'd5};
    @(negedge clk);
    chk("rst_nowr",  rdata, 64'h0);
    chk("rst_noiss", {32'h0, busy_o}, 64'h0);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk({tbl[i].name, "_rd0"},  {32'h0, rdata[31:0]},  {32'h0, tbl[i].e0});
      chk({tbl[i].name, "_rd1"},  {32'h0, rdata[63:32]}, {32'h0, tbl[i].e1});
      chk({tbl[i].name, "_stall"},{63'h0, stall_o},      {63'h0, tbl[i].es});
      chk({tbl[i].name, "_busy"}, {32'h0, busy_o},       {32'h0, tbl[i].eb});
      @(posedge clk); #1;
    end

    // Mid-operation reset: pending result and a concurrent write are discarded.
    idle();
    iss_valid = 1'b1; iss_rd = 5'd6;
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    we = 2'b01; waddr = {5'd0, 5'd20}; wdata = {32'h0, 32'h77}; wb_clr = 2'b00;
    re = 2'b11; raddr = {5'd5, 5'd6};
    @(negedge clk);
    chk("mrst_rdata", rdata, 64'h0);
    chk("mrst_stall", {63'h0, stall_o}, 64'h0);
    chk("mrst_busy",  {32'h0, busy_o}, 64'h40);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    re = 2'b11; raddr = {5'd5, 5'd20};
    @(negedge clk);
    chk("mrst_after_busy",  {32'h0, busy_o}, 64'h0);
    chk("mrst_after_rdata", rdata, 64'h0);
    chk("mrst_after_stall", {63'h0, stall_o}, 64'h0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated per-register busy scoreboard. It serves NRD decode-stage read ports and NWR writeback ports, and forwards same-cycle writes to the read ports. It tracks outstanding destination writes and raises a combinational stall for RAW and WAW hazards against in-flight results, including multi-cycle loads. It replaces the fixed two-read/one-write file and the single-stage load-use check in the decode stage.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, register count (power of two, ≥ 2); AW = log2(NREG)
- NRD, 2, read ports (1..4)
- NWR, 2, write ports (1..3); higher index = higher priority

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  NWR  per-port write enable
- waddr  in  NWR*AW  per-port write address, port k at [k*AW +: AW]
- wdata  in  NWR*XLEN  per-port write data
- wb_clr  in  NWR  per-port "this write retires a scoreboarded result"
- re  in  NRD  per-port read enable
- raddr  in  NRD*AW  per-port read address
- rdata  out  NRD*XLEN  per-port read data, combinational
- iss_valid  in  1  decode issues an instruction this cycle
- iss_rd  in  AW  destination of the issued instruction (0 = none)
- flush  in  1  pipeline flush; drop all pending results
- stall_o  out  1  decode must hold; combinational
- busy_o  out  NREG  scoreboard state, registered

## Operation
- Array: NREG × XLEN. Register 0 reads 0, is never written and is never busy.
- Write: on posedge, for each register r ≠ 0, the highest-index port k with we[k] and waddr[k]==r writes wdata[k]. Lower-priority writes to the same r are dropped.
- Read port j, in priority order:
  - rst → 0
  - raddr==0 or !re[j] → 0
  - same-cycle write to raddr → data from the highest-priority matching write port
  - otherwise → array[raddr]
- Scoreboard busy[r], registered:
  - Set on posedge when iss_valid && !stall_o && iss_rd==r && r≠0.
  - Cleared on posedge when some port k has we[k] && wb_clr[k] && waddr[k]==r.
  - Set and clear for the same r in one cycle → set wins (new producer).
  - flush → all bits cleared. An issue in the same cycle as flush is ignored. Writes in the flush cycle still commit to the array.
- Hazard detection (combinational):
  - raw_j = re[j] && raddr[j]≠0 && busy[raddr[j]] && !(clearing write to raddr[j] this cycle)
  - waw = iss_valid && iss_rd≠0 && busy[iss_rd] && !(clearing write to iss_rd this cycle)
  - stall_o = !rst && !flush && (OR of raw_j || waw)
- A write with wb_clr=0 updates data but leaves busy unchanged; it is used by non-scoreboarded producers.

## Timing
- Read latency 0; forwarded data is valid in the same cycle as the write.
- A write is visible from the array on the cycle after the posedge.
- Issue at cycle t → busy from t+1 → any reader stalls from t+1 until the cycle in which the clearing write is presented. In that cycle the reader gets the forwarded data with stall_o=0.
- Reset: all array entries 0, busy_o 0, stall_o 0, rdata 0 while rst is high. rst mid-operation discards all pending results; writes presented during rst are ignored.

## Structure
- Package regfile_pkg holds:
  - XLEN/NREG defaults and typedefs reg_addr_t, reg_data_t
  - localparam AW
- Sub-module regfile_scoreboard contains the busy vector, set/clear/flush logic and the stall equation.
- The top contains the array, the write arbitration and the forwarding muxes.

## Test plan
- Reset then read: rst for 2 cycles → busy_o=0, every rdata=0. Write r5=0xDEADBEEF via port 0 → next cycle array read of r5 returns 0xDEADBEEF.
- Write conflict and forward: port0 writes r7=0x1111 and port1 writes r7=0x2222 in the same cycle → same-cycle rdata for r7 is 0x2222, and 0x2222 is stored.
- Load-use: issue rd=3 at t → at t+1 raddr0=3 gives stall_o=1. Stall holds for 4 cycles. Port1 write r3=0x55 with wb_clr at t+5 → stall_o=0 and rdata0=0x55 in that cycle; busy_o[3]=0 at t+6.
- WAW and same-cycle set/clear: busy[4] set, then issue rd=4 → stall_o=1. Clearing write to r4 coincides with an issue of rd=4 → stall_o=0 and busy[4] remains 1.
- Flush: busy on r1, r2, r9 plus iss_valid rd=10 with flush → next cycle busy_o=0. A write in the flush cycle still lands.
- x0: issue rd=0 and write r0=0xFFFF → busy_o[0]=0, rdata for r0 = 0, stall_o=0.
